fec_encoder: RTL and testbench
==============================

FEC_ENCODER -- requirements
Module: fec_encoder

Interface
REQ-001 Parameter BLOCK_BITS, default 96: information bits per block; legal range 7..1024.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 DataIn  input  1  randomized serial bit from the upstream randomizer.
REQ-005 en  input  1  DataIn valid; bit accepted on an edge where en=1 and in_ready=1.
REQ-006 in_ready  output  1  block is collecting input bits.
REQ-007 DataOutX  output  1  encoder output X, generator G1 = 171 octal.
REQ-008 DataOutY  output  1  encoder output Y, generator G2 = 133 octal.
REQ-009 out_valid  output  1  DataOutX/DataOutY valid this cycle.
REQ-010 block_done  output  1  one-cycle pulse coincident with the last valid output pair of a block.

Function
REQ-011 Rate-1/2, K=7, tail-biting convolutional encoder: one output pair per information bit, BLOCK_BITS pairs per block.
REQ-012 Input bits are numbered b[0] (first accepted) to b[N-1], N=BLOCK_BITS; b[i] is stored at buffer index i.
REQ-013 FSM states: LOAD, PRIME, ENCODE; reset state LOAD.
REQ-014 LOAD: in_ready=1, out_valid=0; each accepted bit increments a bit counter; after accepting b[N-1], next state PRIME with counter cleared.
REQ-015 PRIME: exactly one cycle; in_ready=0, out_valid=0; encoder shift register loaded s[k]=b[N-1-k], k=0..5 (s[0] most recent); next state ENCODE.
REQ-016 ENCODE: exactly N cycles; in cycle i, d=b[i], out_valid=1, DataOutX = d^s0^s1^s2^s5, DataOutY = d^s1^s2^s4^s5; the shift register then shifts (s[0]<-d).
REQ-017 DataOutX/DataOutY/out_valid are registered; the first valid pair appears in the cycle after PRIME; valid pairs occupy N consecutive cycles with no gaps.
REQ-018 block_done=1 only in the cycle carrying output pair i=N-1; next state LOAD.
REQ-019 Tail-biting property: the shift register state after encoding b[N-1] equals the state loaded in PRIME.
REQ-020 en=1 while in_ready=0 is ignored and the bit is discarded; upstream stalls its randomizer via its own en.
REQ-021 en=0 in LOAD holds the counter and buffer; gaps in input are allowed.
REQ-022 No output backpressure: downstream must accept every pair with out_valid=1.
REQ-023 When out_valid=0, DataOutX and DataOutY are 0.

Reset
REQ-024 reset=1 forces on the next edge: state LOAD, bit counter 0, shift register 0, out_valid=0, DataOutX=0, DataOutY=0, block_done=0, in_ready=1.
REQ-025 Reset mid-block, in any state, abandons the partial block; no stale pair is output afterwards; buffer contents need not be cleared.
REQ-026 reset has priority over en on the same edge.

Structure
REQ-027 Package fec_pkg holds BLOCK_BITS default, K=7, G1=7'b1111001, G2=7'b1011011, and the FSM state enum.
REQ-028 Sub-module conv_encoder_core holds the 6-bit shift register (load, shift, clear) and the G1/G2 XOR taps; fec_encoder holds the buffer, counters and FSM.

Verification
REQ-029 All-zero 96-bit block -> 96 pairs X=0, Y=0; block_done on the 96th pair.
REQ-030 b[0]=1, all other bits 0 -> X pairs 0..6 = 1,1,1,1,0,0,1; Y pairs 0..6 = 1,0,1,1,0,1,1; all later pairs 0.
REQ-031 b[95]=1, all other bits 0 (tail-biting) -> X pairs 0..5 = 1,1,1,0,0,1; Y pairs 0..5 = 0,1,1,0,1,1; pair 95 = (1,1); all others 0.
REQ-032 All-ones block -> all 96 pairs (1,1); in_ready=0 from PRIME through the block_done cycle, then 1.
REQ-033 Upstream randomizer (seed default) feeding 96'hACBCD2114DAE1577C6DBF4C9 -> block input equals 96'h558AC4A53A1724E163AC2BF9; outputs match a golden model; two back-to-back blocks with random en gaps are each encoded correctly.
REQ-034 reset asserted at ENCODE pair 40 -> out_valid=0 on the next edge, in_ready=1, no block_done; next full block is encoded correctly.

Source files
------------

// File: rtl/fec_pkg.sv
// Shared constants, FSM state type and tap helper for the tail-biting K=7 encoder.
package fec_pkg;

    localparam int unsigned BlockBitsDefault = 96;
    localparam int unsigned K                = 7;

    // Generator polynomials; bit 6 taps the input bit, bit (5-k) taps s[k].
    localparam logic [K-1:0] G1 = 7'b1111001;  // 171 octal, output X
    localparam logic [K-1:0] G2 = 7'b1011011;  // 133 octal, output Y

    typedef enum logic [1:0] {
        StLoad,
        StPrime,
        StEncode
    } fec_state_e;

    // Parity of the generator-selected bits of {d, s[0], ..., s[K-2]}.
    function automatic logic conv_tap(input logic [K-1:0] g, input logic d,
                                      input logic [K-2:0] s);
        logic [K-1:0] v;
        v[K-1] = d;
        for (int k = 0; k < K - 1; k++) begin
            v[K-2-k] = s[k];
        end
        return ^(g & v);
    endfunction

endpackage

// File: rtl/fec_encoder_if.sv
// Serial input / paired output bundle of the FEC encoder.
interface fec_encoder_if;

    logic DataIn;
    logic en;
    logic in_ready;
    logic DataOutX;
    logic DataOutY;
    logic out_valid;
    logic block_done;

    // Encoder side.
    modport slave (
        input  DataIn,
        input  en,
        output in_ready,
        output DataOutX,
        output DataOutY,
        output out_valid,
        output block_done
    );

    // Upstream source / downstream sink side.
    modport master (
        output DataIn,
        output en,
        input  in_ready,
        input  DataOutX,
        input  DataOutY,
        input  out_valid,
        input  block_done
    );

endinterface

// File: rtl/conv_encoder_core.sv
// 6-bit convolutional shift register with G1/G2 XOR taps; s[0] is the most recent bit.
module conv_encoder_core
    import fec_pkg::*;
(
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [K-2:0] load_val_i,
    input  logic         shift_i,
    input  logic         d_i,
    output logic         x_o,
    output logic         y_o
);

    logic [K-2:0] sr_q, sr_d;

    // Next shift-register value: load beats shift.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[K-3:0], d_i};
        end
    end

    // Shift-register state with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign x_o = conv_tap(G1, d_i, sr_q);
    assign y_o = conv_tap(G2, d_i, sr_q);

endmodule

// File: rtl/fec_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder: buffers a block, primes, then streams pairs.
module fec_encoder
    import fec_pkg::*;
#(
    parameter int unsigned BLOCK_BITS = BlockBitsDefault
) (
    input  logic          clk,
    input  logic          reset,
    fec_encoder_if.slave  bus
);

    localparam int unsigned      CntW    = $clog2(BLOCK_BITS);
    localparam logic [CntW-1:0]  LastIdx = CntW'(BLOCK_BITS - 1);

    fec_state_e             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BLOCK_BITS-1:0]  buf_q;
    logic                   x_q, x_d;
    logic                   y_q, y_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   emit;
    logic                   sr_load;
    logic                   sr_shift;
    logic                   enc_d;
    logic                   enc_x;
    logic                   enc_y;
    logic [K-2:0]           load_val;

    assign accept = (state_q == StLoad) && bus.en;
    assign enc_d  = buf_q[cnt_q];

    // Tail-biting start state; b[N-1] is still on DataIn on the loading edge, so bypass it.
    always_comb begin
        load_val[0] = bus.DataIn;
        for (int k = 1; k < K - 1; k++) begin
            load_val[k] = buf_q[BLOCK_BITS-1-k];
        end
    end

    conv_encoder_core u_core (
        .clk_i      (clk),
        .clear_i    (reset),
        .load_i     (sr_load),
        .load_val_i (load_val),
        .shift_i    (sr_shift),
        .d_i        (enc_d),
        .x_o        (enc_x),
        .y_o        (enc_y)
    );

    // Next-state logic; the pair computed in a cycle becomes visible in the following one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = 1'b0;
        y_d      = 1'b0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        emit     = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (bus.en) begin
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        sr_load = 1'b1;
                        state_d = StPrime;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StPrime: begin
                emit    = 1'b1;
                state_d = StEncode;
            end
            StEncode: begin
                // done_q marks the cycle showing the last pair of the block.
                if (done_q) begin
                    state_d = StLoad;
                end else begin
                    emit = 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase

        if (emit) begin
            x_d      = enc_x;
            y_d      = enc_y;
            valid_d  = 1'b1;
            sr_shift = 1'b1;
            if (cnt_q == LastIdx) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Control state and registered outputs; reset overrides any input activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Block buffer: b[i] lands at index i; contents are never cleared.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            buf_q[cnt_q] <= bus.DataIn;
        end
    end

    assign bus.in_ready   = (state_q == StLoad);
    assign bus.DataOutX   = x_q;
    assign bus.DataOutY   = y_q;
    assign bus.out_valid  = valid_q;
    assign bus.block_done = done_q;

endmodule

// File: tb/tb_fec_encoder.sv
// Directed bench for fec_encoder: impulse, constant, golden-model and reset scenarios.
module tb_fec_encoder;

    localparam int N = 96;

    logic clk;
    logic reset;
    int   vectors = 0;
    int   fails   = 0;

    fec_encoder_if bus ();

    fec_encoder #(.BLOCK_BITS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder; blk[N-1] is b[0], the first bit sent.
    function automatic void model(input logic [N-1:0] blk, output logic [N-1:0] ex,
                                  output logic [N-1:0] ey);
        logic [5:0] s;
        logic       d;
        for (int k = 0; k < 6; k++) s[k] = blk[k];
        for (int i = 0; i < N; i++) begin
            d     = blk[N-1-i];
            ex[i] = d ^ s[0] ^ s[1] ^ s[2] ^ s[5];
            ey[i] = d ^ s[1] ^ s[2] ^ s[4] ^ s[5];
            s     = {s[4:0], d};
        end
    endfunction

    task automatic feed_block(input logic [N-1:0] blk, input bit gaps, input string name);
        int g;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge clk);
                    bus.en     = 1'b0;
                    bus.DataIn = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL %s in_ready before bit %0d: got %b want 1", name, i, bus.in_ready);
            end
            bus.en     = 1'b1;
            bus.DataIn = blk[N-1-i];
        end
        @(negedge clk);
        bus.en = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s prime cycle: got in_ready=%b out_valid=%b want 0 0",
                     name, bus.in_ready, bus.out_valid);
        end
    endtask

    // Collects one block of pairs while driving ignored junk on en/DataIn.
    task automatic collect_check(input logic [N-1:0] ex, input logic [N-1:0] ey,
                                 input string name);
        logic [N-1:0] gx, gy, gd;
        int   idx, cyc, first_cyc, bad_rdy, bad_idle;
        bit   done_seen;
        logic exp_d;
        gx = '0; gy = '0; gd = '0;
        idx = 0; cyc = 0; first_cyc = -1; bad_rdy = 0; bad_idle = 0; done_seen = 0;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.en     = 1'($urandom_range(0, 1));
            bus.DataIn = 1'($urandom_range(0, 1));
            if (bus.out_valid === 1'b1) begin
                if (idx == 0) first_cyc = cyc;
                if (idx < N) begin
                    gx[idx] = bus.DataOutX;
                    gy[idx] = bus.DataOutY;
                    gd[idx] = bus.block_done;
                end
                if (bus.in_ready !== 1'b0) bad_rdy++;
                idx++;
                if (bus.block_done === 1'b1) done_seen = 1;
            end else if (bus.DataOutX !== 1'b0 || bus.DataOutY !== 1'b0 ||
                         bus.block_done !== 1'b0) begin
                bad_idle++;
            end
        end
        bus.en = 1'b0;

        vectors++;
        if (!done_seen) begin
            fails++;
            $display("FAIL %s block_done: got none in 200 cycles, want one", name);
        end
        vectors++;
        if (idx != N) begin
            fails++;
            $display("FAIL %s pair count: got %0d want %0d", name, idx, N);
        end
        vectors++;
        if (first_cyc != 1) begin
            fails++;
            $display("FAIL %s first pair latency: got cycle %0d want 1", name, first_cyc);
        end
        vectors++;
        if (cyc - first_cyc + 1 != idx) begin
            fails++;
            $display("FAIL %s contiguity: got span %0d want %0d", name, cyc - first_cyc + 1, idx);
        end
        for (int i = 0; i < N; i++) begin
            exp_d = (i == N - 1);
            vectors++;
            if (gx[i] !== ex[i] || gy[i] !== ey[i] || gd[i] !== exp_d) begin
                fails++;
                $display("FAIL %s pair %0d: got x=%b y=%b done=%b want x=%b y=%b done=%b",
                         name, i, gx[i], gy[i], gd[i], ex[i], ey[i], exp_d);
            end
        end
        vectors++;
        if (bad_rdy != 0 || bad_idle != 0) begin
            fails++;
            $display("FAIL %s side signals: got %0d in_ready / %0d idle errors want 0 0",
                     name, bad_rdy, bad_idle);
        end
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s after block: got in_ready=%b out_valid=%b want 1 0",
                     name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.en     = 1'b1;
        bus.DataIn = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.DataOutX !== 1'b0 || bus.DataOutY !== 1'b0) begin
            fails++;
            $display("FAIL reset data: got x=%b y=%b want 0 0", bus.DataOutX, bus.DataOutY);
        end
        vectors++;
        if (bus.block_done !== 1'b0) begin
            fails++; $display("FAIL reset block_done: got %b want 0", bus.block_done);
        end
        reset  = 1'b0;
        bus.en = 1'b0;
    endtask

    task automatic test_all_zero();
        feed_block('0, 1'b0, "all_zero");
        collect_check('0, '0, "all_zero");
    endtask

    task automatic test_impulse_first();
        logic [N-1:0] blk, ex, ey;
        blk = '0; blk[N-1] = 1'b1;
        ex = '0; ex[6:0] = 7'b1001111;
        ey = '0; ey[6:0] = 7'b1101101;
        feed_block(blk, 1'b0, "impulse_first");
        collect_check(ex, ey, "impulse_first");
    endtask

    task automatic test_impulse_last();
        logic [N-1:0] blk, ex, ey;
        blk = '0; blk[0] = 1'b1;
        ex = '0; ex[5:0] = 6'b100111; ex[N-1] = 1'b1;
        ey = '0; ey[5:0] = 6'b110110; ey[N-1] = 1'b1;
        feed_block(blk, 1'b0, "impulse_last");
        collect_check(ex, ey, "impulse_last");
    endtask

    task automatic test_all_ones();
        feed_block('1, 1'b0, "all_ones");
        collect_check('1, '1, "all_ones");
    endtask

    task automatic test_golden();
        logic [N-1:0] blk, ex, ey;
        blk = 96'h558AC4A53A1724E163AC2BF9;
        model(blk, ex, ey);
        feed_block(blk, 1'b0, "golden");
        collect_check(ex, ey, "golden");
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] blk, ex, ey;
        blk = 96'hACBCD2114DAE1577C6DBF4C9;
        model(blk, ex, ey);
        feed_block(blk, 1'b1, "b2b_first");
        collect_check(ex, ey, "b2b_first");
        blk = 96'h558AC4A53A1724E163AC2BF9;
        model(blk, ex, ey);
        feed_block(blk, 1'b1, "b2b_second");
        collect_check(ex, ey, "b2b_second");
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] blk, ex, ey;
        int idx, cyc, bad;
        feed_block(96'hF0F0_1234_5678_9ABC_DEF0_0F0F, 1'b0, "mid_reset");
        idx = 0; cyc = 0;
        while (idx < 41 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) idx++;
        end
        vectors++;
        if (idx != 41) begin
            fails++; $display("FAIL mid_reset reach pair 40: got %0d pairs want 41", idx);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.block_done !== 1'b0 ||
            bus.DataOutX !== 1'b0 || bus.DataOutY !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset abort: got valid=%b rdy=%b done=%b x=%b y=%b want 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, bus.block_done, bus.DataOutX, bus.DataOutY);
        end
        reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.block_done !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            fails++; $display("FAIL mid_reset stale output: got %0d bad cycles want 0", bad);
        end
        blk = 96'h0123456789ABCDEF13579BDF;
        model(blk, ex, ey);
        feed_block(blk, 1'b0, "after_reset");
        collect_check(ex, ey, "after_reset");
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.DataIn = 1'b0;
        test_reset();
        test_all_zero();
        test_impulse_first();
        test_impulse_last();
        test_all_ones();
        test_golden();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
